// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Prefetch entries pair each instruction with the address that follows it.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [31:0] next_pc;
    } fetch_entry_t;

    localparam logic [15:0] NOP_INSTR   = 16'hFFFF;
    localparam logic [31:0] INSTR_BYTES = 32'd2;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch entries with flush, occupancy count and full/empty flags.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  fetch_entry_t     entry_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers/count decide what is valid, so no reset fan-out is needed.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= entry_i;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, request FSM, prefetch FIFO and decode-facing outputs.
// At most one memory request is outstanding; branches flush and may discard its response.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        stall_pc_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        end_program_i,
    input  logic        mem_busy_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [15:0] imem_rdata_i,
    output logic [15:0] instr_o,
    output logic        instr_en_o,
    output logic [31:0] next_programm_counter_o
);

    localparam int            CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_OCC  = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [31:0]   RESET_PC_AL = {RESET_PC[31:1], 1'b0};

    fetch_state_t     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic             outstanding_q, outstanding_d;
    logic             discard_q, discard_d;
    logic             issue;

    fetch_entry_t     head;
    fetch_entry_t     push_entry;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             resp_valid;
    logic [CNT_W:0]   occupancy;
    logic             can_issue;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .entry_i (push_entry),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .head_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign instr_en_o              = ~fifo_empty & ~branch_i & (state_q != HALT);
    assign instr_o                 = fifo_empty ? NOP_INSTR : head.instr;
    assign next_programm_counter_o = fifo_empty ? 32'h0 : head.next_pc;

    assign fifo_pop   = instr_en_o & ~stall_i & ~stall_pc_i;
    assign fifo_flush = branch_i & ~end_program_i & (state_q != HALT);
    assign resp_valid = (state_q == WAIT) & outstanding_q & imem_rvalid_i;
    assign fifo_push  = resp_valid & ~discard_q & ~branch_i & ~end_program_i
                      & (~fifo_full | fifo_pop);
    assign push_entry = '{instr: imem_rdata_i, next_pc: req_addr_q + INSTR_BYTES};

    // Occupancy after this cycle's push/pop, so a response landing now still leaves room for the next one.
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(fifo_push) - (CNT_W + 1)'(fifo_pop);
    assign can_issue = ~mem_busy_i & (occupancy < DEPTH_OCC);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        req_addr_d    = req_addr_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        issue         = 1'b0;

        if (end_program_i || state_q == HALT) begin
            state_d       = HALT;
            outstanding_d = 1'b0;
            discard_d     = 1'b0;
        end else if (branch_i) begin
            fetch_pc_d = {branch_target_i[31:1], 1'b0};
            if (state_q == WAIT && outstanding_q && !imem_rvalid_i) begin
                discard_d = 1'b1;
            end else begin
                state_d       = FETCH;
                outstanding_d = 1'b0;
                discard_d     = 1'b0;
            end
        end else begin
            unique case (state_q)
                IDLE:  state_d = FETCH;
                FETCH: issue = can_issue;
                WAIT: begin
                    if (imem_rvalid_i) begin
                        outstanding_d = 1'b0;
                        discard_d     = 1'b0;
                        if (can_issue) issue = 1'b1;
                        else           state_d = FETCH;
                    end
                end
                default: state_d = HALT;
            endcase
        end

        if (issue) begin
            state_d       = WAIT;
            req_addr_d    = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + INSTR_BYTES;
            outstanding_d = 1'b1;
        end
    end

    assign imem_req_o  = issue;
    assign imem_addr_o = issue ? fetch_pc_q : 32'h0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC_AL;
            req_addr_q    <= 32'h0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            req_addr_q    <= req_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1- or 2-cycle latency instruction memory model.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        stall_pc_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        end_program_i;
    logic        mem_busy_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [15:0] imem_rdata_i;
    logic [15:0] instr_o;
    logic        instr_en_o;
    logic [31:0] next_programm_counter_o;

    int checks   = 0;
    int failures = 0;
    int mem_lat  = 1;

    fetch_stage dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .stall_i                 (stall_i),
        .stall_pc_i              (stall_pc_i),
        .branch_i                (branch_i),
        .branch_target_i         (branch_target_i),
        .end_program_i           (end_program_i),
        .mem_busy_i              (mem_busy_i),
        .imem_req_o              (imem_req_o),
        .imem_addr_o             (imem_addr_o),
        .imem_rvalid_i           (imem_rvalid_i),
        .imem_rdata_i            (imem_rdata_i),
        .instr_o                 (instr_o),
        .instr_en_o              (instr_en_o),
        .next_programm_counter_o (next_programm_counter_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory contents: 0x2001 at 0x0, then +0x0101 per halfword (0x2102 at 0x2, 0x2304 at 0x6).
    function automatic logic [15:0] mem_word(input logic [31:0] addr);
        logic [15:0] idx;
        idx = addr[16:1];
        return 16'h2001 + idx * 16'h0101;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic wait_req(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk_i);
            found = imem_req_o;
        end
    endtask

    task automatic wait_en(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk_i);
            found = instr_en_o;
        end
    endtask

    // Memory model: a request seen on the falling edge is answered mem_lat cycles later.
    initial begin : mem_model
        logic        pend;
        logic [31:0] paddr;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 16'h0;
        forever begin
            @(negedge clk_i);
            pend  = imem_req_o;
            paddr = imem_addr_o;
            @(posedge clk_i);
            #1;
            if (pend && mem_lat == 2) begin
                imem_rvalid_i = 1'b0;
                @(posedge clk_i);
                #1;
            end
            imem_rvalid_i = pend;
            imem_rdata_i  = pend ? mem_word(paddr) : 16'h0;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit found;

        rst_i = 1'b0; stall_i = 1'b0; stall_pc_i = 1'b0; branch_i = 1'b0;
        branch_target_i = 32'h0; end_program_i = 1'b0; mem_busy_i = 1'b0;

        // Reset values
        next_cycle(); next_cycle(); settle();
        check("rst_req",   imem_req_o, 1'b0);
        check("rst_addr",  imem_addr_o, 32'h0);
        check("rst_en",    instr_en_o, 1'b0);
        check("rst_instr", instr_o, 16'hFFFF);
        check("rst_npc",   next_programm_counter_o, 32'h0);

        // 1: release, IDLE one cycle, then back-to-back fetch at 1-cycle latency
        next_cycle(); rst_i = 1'b1; settle();
        check("t1_idle_req", imem_req_o, 1'b0);
        next_cycle(); settle();
        check("t1_req0",  imem_req_o, 1'b1);
        check("t1_addr0", imem_addr_o, 32'h0);
        next_cycle(); settle();
        check("t1_req2",  imem_req_o, 1'b1);
        check("t1_addr2", imem_addr_o, 32'h2);
        next_cycle(); settle();
        check("t1_en_a",    instr_en_o, 1'b1);
        check("t1_instr_a", instr_o, 16'h2001);
        check("t1_npc_a",   next_programm_counter_o, 32'h2);
        next_cycle(); settle();
        check("t1_en_b",    instr_en_o, 1'b1);
        check("t1_instr_b", instr_o, 16'h2102);
        check("t1_npc_b",   next_programm_counter_o, 32'h4);

        // 2: stall with head 0x2203, FIFO fills, then in-order drain
        for (int i = 0; i < 3; i++) begin
            next_cycle(); stall_i = 1'b1; settle();
            check("t2_stall_en",    instr_en_o, 1'b1);
            check("t2_stall_instr", instr_o, 16'h2203);
            check("t2_stall_npc",   next_programm_counter_o, 32'h6);
            if (i > 0) check("t2_full_noreq", imem_req_o, 1'b0);
        end
        next_cycle(); stall_i = 1'b0; settle();
        check("t2_drain0_instr", instr_o, 16'h2203);
        check("t2_drain0_npc",   next_programm_counter_o, 32'h6);
        next_cycle(); settle();
        check("t2_drain1_en",    instr_en_o, 1'b1);
        check("t2_drain1_instr", instr_o, 16'h2304);
        check("t2_drain1_npc",   next_programm_counter_o, 32'h8);
        next_cycle(); settle();
        check("t2_drain2_en",    instr_en_o, 1'b1);
        check("t2_drain2_instr", instr_o, 16'h2405);
        check("t2_drain2_npc",   next_programm_counter_o, 32'hA);

        // 3: 2-cycle memory; branch while request to 0x6 is outstanding
        next_cycle(); rst_i = 1'b0;
        next_cycle(); mem_lat = 2;
        next_cycle(); rst_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk_i);
            found = imem_req_o && (imem_addr_o == 32'h6);
        end
        check("t3_req6_seen", found, 1'b1);
        next_cycle(); branch_i = 1'b1; branch_target_i = 32'h101; settle();
        check("t3_br_en",  instr_en_o, 1'b0);
        check("t3_br_req", imem_req_o, 1'b0);
        next_cycle(); branch_i = 1'b0;
        wait_req(10, found);
        check("t3_redir_seen", found, 1'b1);
        check("t3_redir_addr", imem_addr_o, 32'h100);
        wait_en(10, found);
        check("t3_first_seen",  found, 1'b1);
        check("t3_first_instr", instr_o, mem_word(32'h100));
        check("t3_first_npc",   next_programm_counter_o, 32'h102);

        // 4: branch to 0x200 with memory busy for the branch cycle plus 4 more
        next_cycle(); branch_i = 1'b1; branch_target_i = 32'h200; mem_busy_i = 1'b1; settle();
        check("t4_busy_req_br", imem_req_o, 1'b0);
        for (int i = 0; i < 4; i++) begin
            next_cycle(); branch_i = 1'b0; settle();
            check("t4_busy_req", imem_req_o, 1'b0);
        end
        next_cycle(); mem_busy_i = 1'b0; settle();
        check("t4_resume_req",  imem_req_o, 1'b1);
        check("t4_resume_addr", imem_addr_o, 32'h200);
        wait_en(10, found);
        check("t4_first_seen",  found, 1'b1);
        check("t4_first_instr", instr_o, mem_word(32'h200));
        check("t4_first_npc",   next_programm_counter_o, 32'h202);

        // 5: end_program pulse halts fetch permanently
        next_cycle(); end_program_i = 1'b1; settle();
        check("t5_end_en",  instr_en_o, 1'b0);
        check("t5_end_req", imem_req_o, 1'b0);
        next_cycle(); end_program_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            settle();
            check("t5_halt_req", imem_req_o, 1'b0);
            check("t5_halt_en",  instr_en_o, 1'b0);
            next_cycle();
        end

        // 6: reset mid-WAIT, late response ignored, then PC wrap
        rst_i = 1'b0;
        next_cycle();
        next_cycle(); rst_i = 1'b1;
        wait_req(10, found);
        check("t6_req_seen", found, 1'b1);
        check("t6_req_addr", imem_addr_o, 32'h0);
        next_cycle(); rst_i = 1'b0; #1;
        check("t6_rst_req",   imem_req_o, 1'b0);
        check("t6_rst_addr",  imem_addr_o, 32'h0);
        check("t6_rst_en",    instr_en_o, 1'b0);
        check("t6_rst_instr", instr_o, 16'hFFFF);
        check("t6_rst_npc",   next_programm_counter_o, 32'h0);
        next_cycle(); rst_i = 1'b1; settle();
        check("t6_late_rvalid_present", imem_rvalid_i, 1'b1);
        check("t6_idle_req", imem_req_o, 1'b0);
        next_cycle(); settle();
        check("t6_late_ignored_en", instr_en_o, 1'b0);
        check("t6_restart_req",  imem_req_o, 1'b1);
        check("t6_restart_addr", imem_addr_o, 32'h0);
        next_cycle(); branch_i = 1'b1; branch_target_i = 32'hFFFF_FFFF; settle();
        next_cycle(); branch_i = 1'b0;
        wait_req(10, found);
        check("t6_top_seen", found, 1'b1);
        check("t6_top_addr", imem_addr_o, 32'hFFFF_FFFE);
        wait_req(10, found);
        check("t6_wrap_seen", found, 1'b1);
        check("t6_wrap_addr", imem_addr_o, 32'h0);
        wait_en(10, found);
        check("t6_top_en_seen", found, 1'b1);
        check("t6_top_instr",   instr_o, mem_word(32'hFFFF_FFFE));
        check("t6_top_npc",     next_programm_counter_o, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
